// File: rtl/seq_divider.sv
// Sequential restoring shift-subtract divider: 2*DW-bit dividend / DW-bit divisor,
// one quotient bit per clock, load/valid handshake matching the shift-add multiplier.
module seq_divider #(
   parameter int DW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [2*DW-1:0]   dividend,
   input  logic [DW-1:0]     divisor,
   output logic [2*DW-1:0]   quotient,
   output logic [DW-1:0]     remainder,
   output logic              busy,
   output logic              valid,
   output logic              div_zero
);

   // state | meaning
   // IDLE  | no result yet, waiting for load
   // RUN   | one restoring iteration per clock, 2*DW in total
   // DONE  | quotient/remainder valid, held until next load
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam int CW = $clog2(2*DW);
   localparam logic [CW-1:0] LAST = CW'(2*DW-1);

   state_t          state, state_nxt;
   logic [2*DW-1:0] dvd_q;
   logic [DW-1:0]   dsr_q;
   logic [DW:0]     prem_q;
   logic [CW-1:0]   cnt;

   logic            accept;
   logic [DW+1:0]   shifted;
   logic [DW+1:0]   trial;
   logic            ge;
   logic [DW:0]     prem_nxt;
   logic [2*DW-1:0] dvd_nxt;

   assign accept = load && (state != RUN);

   // The dividend register doubles as the quotient shift register: each shift
   // pushes one dividend bit out of the MSB and one quotient bit into the LSB.
   assign shifted  = {prem_q, dvd_q[2*DW-1]};
   assign trial    = shifted - {2'b00, dsr_q};
   assign ge       = ~trial[DW+1];
   assign prem_nxt = ge ? trial[DW:0] : shifted[DW:0];
   assign dvd_nxt  = {dvd_q[2*DW-2:0], ge};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (load) state_nxt = (divisor == '0) ? DONE : RUN;
         RUN:        if (cnt == LAST) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state == RUN);
      valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dvd_q     <= '0;
         dsr_q     <= '0;
         prem_q    <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else if (accept) begin
         dvd_q    <= dividend;
         dsr_q    <= divisor;
         prem_q   <= '0;
         cnt      <= '0;
         div_zero <= (divisor == '0);
         if (divisor == '0) begin
            quotient  <= '1;
            remainder <= dividend[DW-1:0];
         end
      end else if (state == RUN) begin
         dvd_q  <= dvd_nxt;
         prem_q <= prem_nxt;
         cnt    <= cnt + CW'(1);
         if (cnt == LAST) begin
            quotient  <= dvd_nxt;
            remainder <= prem_nxt[DW-1:0];
         end
      end
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring shift-subtract divider. It is the inverse datapath of the team's 8x8 shift-add multiplier.
- Takes a 2*DW-bit dividend and a DW-bit divisor. Produces a 2*DW-bit quotient and a DW-bit remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit and uses the same load/valid style. It is used to check products by dividing them back.

Parameters:
- DW, 8, divisor and remainder width; dividend and quotient are 2*DW bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  start request; sampled on the rising edge of clk.
- dividend  input  2*DW  numerator; captured only on an accepted load.
- divisor  input  DW  denominator; captured only on an accepted load.
- quotient  output  2*DW  registered result.
- remainder  output  DW  registered result.
- busy  output  1  high while an iteration sequence is in progress.
- valid  output  1  high while quotient and remainder hold a completed result.
- div_zero  output  1  high with valid when the captured divisor was 0.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - quotient=0, remainder=0, busy=0, valid=0, div_zero=0.
  - Iteration counter and internal registers are cleared.
  - Reset applied mid-RUN aborts the operation immediately. No result is produced after release.
- States are IDLE, RUN and DONE. busy=1 only in RUN. valid=1 only in DONE.
- Load acceptance:
  - load=1 at a rising edge while in IDLE or DONE is accepted.
  - On acceptance, dividend and divisor are captured into internal registers. The partial remainder register (DW+1 bits) is cleared, the counter is set to 0, and valid and div_zero are cleared.
  - Next state is RUN, or DONE-with-div_zero if divisor==0.
  - load in RUN is ignored. The operation and the captured operands are unaffected.
- RUN iteration, one per rising edge:
  - Shift the partial remainder left 1 bit, bringing in the dividend register MSB. Shift the dividend register left 1 bit.
  - Trial value = partial remainder − {1'b0, divisor}, computed at DW+1 bits.
  - If the trial value is non-negative: partial remainder = trial value and quotient bit = 1. Otherwise keep the partial remainder and quotient bit = 0.
  - The quotient bit shifts into the quotient shift register LSB. The counter increments.
- Completion:
  - On the edge that performs iteration 2*DW (counter == 2*DW−1), state goes to DONE.
  - On that same edge, quotient and remainder outputs load from the internal registers and valid goes to 1.
  - Latency: load accepted at edge k gives valid=1 after edge k+2*DW, i.e. 16 cycles for DW=8. Throughput is one division per 2*DW+1 cycles when load is reasserted in DONE.
- Divide by zero:
  - Load with divisor==0 goes directly to DONE at edge k+1. No RUN.
  - quotient = all ones, remainder = dividend[DW-1:0], div_zero=1, valid=1.
- DONE holds all outputs and valid until the next accepted load or reset. It does not return to IDLE on its own.
- Output hold: quotient and remainder change only on entry to DONE or on reset. They are not updated during RUN.
- Load in DONE: the edge that accepts the load drops valid the same cycle and goes to RUN. The previous outputs remain visible but valid=0.
- Arithmetic: unsigned only. The invariant dividend == quotient*divisor + remainder with remainder < divisor must hold for every divisor != 0.

Test Plan:
- Basic: reset, then load dividend=65025, divisor=255 → after 16 cycles valid=1, quotient=255, remainder=0, div_zero=0, busy low in the same cycle.
- Remainder: dividend=1000, divisor=7 → quotient=142, remainder=6. Then dividend=100, divisor=200 → quotient=0, remainder=100.
- Extremes: dividend=65535, divisor=1 → quotient=65535, remainder=0. Then dividend=16384, divisor=128 → quotient=128, remainder=0.
- Divide by zero: dividend=0x1234, divisor=0 → next cycle valid=1, div_zero=1, quotient=0xFFFF, remainder=0x34, busy never high.
- Load in RUN: pulse load with new operands 5 cycles after start → ignored; the original result appears at cycle 16.
- Reset abort and back-to-back:
  - Assert rst low asynchronously mid-RUN (between edges) → all outputs 0 immediately; no valid after release.
  - Then load in DONE with a new operand pair → valid drops the same cycle; the new result arrives 16 cycles later.
  - Self-check every case against dividend/divisor and dividend%divisor.
